// File: rtl/mii_net_crc_engine_if.sv
// Input beat stream, FCS output stream and verdict/CRC results of the CRC-32 engine.
interface mii_net_crc_engine_if #(
   parameter int unsigned DATA_BYTES = 4
);
   logic                      i_mode;
   logic                      i_abort;
   logic                      i_valid;
   logic                      o_ready;
   logic [8*DATA_BYTES-1:0]   i_data;
   logic [DATA_BYTES-1:0]     i_keep;
   logic                      i_last;
   logic [31:0]               o_crc;
   logic                      o_fcs_valid;
   logic                      i_fcs_ready;
   logic [8*DATA_BYTES-1:0]   o_fcs_data;
   logic                      o_fcs_last;
   logic                      o_chk_valid;
   logic                      o_chk_ok;

   modport slave (
      input  i_mode, i_abort, i_valid, i_data, i_keep, i_last, i_fcs_ready,
      output o_ready, o_crc, o_fcs_valid, o_fcs_data, o_fcs_last, o_chk_valid, o_chk_ok
   );

   modport master (
      output i_mode, i_abort, i_valid, i_data, i_keep, i_last, i_fcs_ready,
      input  o_ready, o_crc, o_fcs_valid, o_fcs_data, o_fcs_last, o_chk_valid, o_chk_ok
   );
endinterface

// File: rtl/mii_net_crc_engine.sv
// Multi-byte Ethernet CRC-32 engine: folds DATA_BYTES bytes per beat, then either
// streams the FCS out (generate) or reports a residue verdict (check).
module mii_net_crc_engine #(
   parameter int unsigned DATA_BYTES = 4,
   parameter logic [31:0] INIT       = 32'hFFFF_FFFF,
   parameter logic [31:0] XOR_OUT    = 32'hFFFF_FFFF,
   parameter logic [31:0] RESIDUE    = 32'hDEBB_20E3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   mii_net_crc_engine_if.slave   bus
);

   localparam int unsigned DW     = 8 * DATA_BYTES;
   localparam int unsigned NBEATS = 4 / DATA_BYTES;
   localparam logic [31:0] POLY   = 32'hEDB8_8320;

   typedef enum logic {ACC, EMIT} state_e;

   state_e           state_q;
   logic [31:0]      acc_q;
   logic [31:0]      acc_d;
   logic [31:0]      crc_d;
   logic [31:0]      crc_q;
   logic             ready_q;
   logic             fcs_valid_q;
   logic [DW-1:0]    fcs_data_q;
   logic             fcs_last_q;
   logic [1:0]       beat_q;
   logic             chk_valid_q;
   logic             chk_ok_q;
   logic             accept;
   logic             fcs_fire;

   // Reflected CRC-32 of one byte; equivalent to T[acc[7:0]^b] ^ (acc >> 8).
   function automatic logic [31:0] crc_byte(input logic [31:0] acc, input logic [7:0] b);
      logic [31:0] c;
      c = acc ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [DW-1:0] fcs_slice(input logic [31:0] crc, input logic [1:0] beat);
      return DW'(crc >> (32'(beat) * DW));
   endfunction

   // Fold enabled bytes in wire order; disabled bytes are skipped.
   always_comb begin
      logic [DW-1:0]         d;
      logic [DATA_BYTES-1:0] k;
      acc_d = acc_q;
      d     = bus.i_data;
      k     = bus.i_keep;
      for (int unsigned n = 0; n < DATA_BYTES; n++) begin
         if (k[0]) acc_d = crc_byte(acc_d, d[7:0]);
         d = d >> 8;
         k = k >> 1;
      end
   end

   assign crc_d    = acc_d ^ XOR_OUT;
   assign accept   = bus.i_valid & ready_q;
   assign fcs_fire = fcs_valid_q & bus.i_fcs_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ACC;
         acc_q       <= INIT;
         crc_q       <= 32'd0;
         ready_q     <= 1'b1;
         fcs_valid_q <= 1'b0;
         fcs_data_q  <= '0;
         fcs_last_q  <= 1'b0;
         beat_q      <= 2'd0;
         chk_valid_q <= 1'b0;
         chk_ok_q    <= 1'b0;
      end else begin
         chk_valid_q <= 1'b0;
         if (bus.i_abort) begin
            // Abort drops the in-flight frame or FCS stream; last CRC stays visible.
            state_q     <= ACC;
            acc_q       <= INIT;
            ready_q     <= 1'b1;
            fcs_valid_q <= 1'b0;
            fcs_last_q  <= 1'b0;
            beat_q      <= 2'd0;
         end else begin
            case (state_q)
               ACC: begin
                  if (accept) begin
                     if (bus.i_last) begin
                        acc_q <= INIT;
                        crc_q <= crc_d;
                        if (bus.i_mode) begin
                           chk_valid_q <= 1'b1;
                           chk_ok_q    <= (acc_d == RESIDUE);
                        end else begin
                           state_q     <= EMIT;
                           ready_q     <= 1'b0;
                           fcs_valid_q <= 1'b1;
                           fcs_data_q  <= fcs_slice(crc_d, 2'd0);
                           fcs_last_q  <= (NBEATS == 1);
                           beat_q      <= 2'd0;
                        end
                     end else begin
                        acc_q <= acc_d;
                     end
                  end
               end
               EMIT: begin
                  if (fcs_fire) begin
                     if (fcs_last_q) begin
                        state_q     <= ACC;
                        ready_q     <= 1'b1;
                        fcs_valid_q <= 1'b0;
                        fcs_last_q  <= 1'b0;
                     end else begin
                        beat_q     <= beat_q + 2'd1;
                        fcs_data_q <= fcs_slice(crc_q, beat_q + 2'd1);
                        fcs_last_q <= ((32'(beat_q) + 32'd2) == NBEATS);
                     end
                  end
               end
               default: begin
                  state_q <= ACC;
                  ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_crc       = crc_q;
   assign bus.o_fcs_valid = fcs_valid_q;
   assign bus.o_fcs_data  = fcs_data_q;
   assign bus.o_fcs_last  = fcs_last_q;
   assign bus.o_chk_valid = chk_valid_q;
   assign bus.o_chk_ok    = chk_ok_q;

endmodule

// File: tb/tb_mii_net_crc_engine.sv
// Directed bench for the CRC-32 engine at DATA_BYTES = 4, 2 and 1.
module tb_mii_net_crc_engine;

   logic clk = 1'b0;
   logic rst4, rst2, rst1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mii_net_crc_engine_if #(.DATA_BYTES(4)) if4 ();
   mii_net_crc_engine_if #(.DATA_BYTES(2)) if2 ();
   mii_net_crc_engine_if #(.DATA_BYTES(1)) if1 ();

   mii_net_crc_engine #(.DATA_BYTES(4)) u4 (.i_clk(clk), .i_reset(rst4), .bus(if4));
   mii_net_crc_engine #(.DATA_BYTES(2)) u2 (.i_clk(clk), .i_reset(rst2), .bus(if2));
   mii_net_crc_engine #(.DATA_BYTES(1)) u1 (.i_clk(clk), .i_reset(rst1), .bus(if1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Each send presents one beat at a negedge and returns at the next negedge.
   task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l, input logic m);
      if4.i_valid = 1'b1; if4.i_data = d; if4.i_keep = k; if4.i_last = l; if4.i_mode = m;
      @(negedge clk);
      if4.i_valid = 1'b0; if4.i_last = 1'b0;
   endtask

   task automatic send2(input logic [15:0] d, input logic [1:0] k, input logic l, input logic m);
      if2.i_valid = 1'b1; if2.i_data = d; if2.i_keep = k; if2.i_last = l; if2.i_mode = m;
      @(negedge clk);
      if2.i_valid = 1'b0; if2.i_last = 1'b0;
   endtask

   task automatic send1(input logic [7:0] d, input logic l, input logic m);
      if1.i_valid = 1'b1; if1.i_data = d; if1.i_keep = 1'b1; if1.i_last = l; if1.i_mode = m;
      @(negedge clk);
      if1.i_valid = 1'b0; if1.i_last = 1'b0;
   endtask

   task automatic frame4_123456789();
      send4(32'h3433_3231, 4'hF, 1'b0, 1'b0);
      send4(32'h3837_3635, 4'hF, 1'b0, 1'b0);
      send4(32'h0000_0039, 4'h1, 1'b1, 1'b0);
   endtask

   task automatic frame1_123456789();
      for (int i = 0; i < 8; i++) send1(8'(32'h31 + i), 1'b0, 1'b0);
      send1(8'h39, 1'b1, 1'b0);
   endtask

   task automatic frame2_check(input logic [15:0] third);
      send2(16'h3231, 2'b11, 1'b0, 1'b1);
      send2(16'h3433, 2'b11, 1'b0, 1'b1);
      send2(third,    2'b11, 1'b0, 1'b1);
      send2(16'h3837, 2'b11, 1'b0, 1'b1);
      send2(16'h2639, 2'b11, 1'b0, 1'b1);
      send2(16'hF439, 2'b11, 1'b0, 1'b1);
      send2(16'h00CB, 2'b01, 1'b1, 1'b1);
   endtask

   initial begin
      {if4.i_mode, if4.i_abort, if4.i_valid, if4.i_last} = '0;
      {if2.i_mode, if2.i_abort, if2.i_valid, if2.i_last} = '0;
      {if1.i_mode, if1.i_abort, if1.i_valid, if1.i_last} = '0;
      if4.i_data = '0; if4.i_keep = '0; if4.i_fcs_ready = 1'b1;
      if2.i_data = '0; if2.i_keep = '0; if2.i_fcs_ready = 1'b1;
      if1.i_data = '0; if1.i_keep = '0; if1.i_fcs_ready = 1'b1;
      rst4 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_crc",       if4.o_crc,       32'd0);
      chk("rst_fcs_valid", 32'(if4.o_fcs_valid), 32'd0);
      chk("rst_fcs_data",  if4.o_fcs_data,  32'd0);
      chk("rst_fcs_last",  32'(if4.o_fcs_last),  32'd0);
      chk("rst_chk_valid", 32'(if4.o_chk_valid), 32'd0);
      chk("rst_chk_ok",    32'(if4.o_chk_ok),    32'd0);
      chk("rst_ready",     32'(if4.o_ready),     32'd1);
      rst4 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;

      // 4-byte generate of "123456789"
      frame4_123456789();
      chk("g4_crc",       if4.o_crc,       32'hCBF4_3926);
      chk("g4_fcs_valid", 32'(if4.o_fcs_valid), 32'd1);
      chk("g4_fcs_data",  if4.o_fcs_data,  32'hCBF4_3926);
      chk("g4_fcs_last",  32'(if4.o_fcs_last),  32'd1);
      chk("g4_ready_low", 32'(if4.o_ready),     32'd0);
      @(negedge clk);
      chk("g4_ready_back", 32'(if4.o_ready),     32'd1);
      chk("g4_fcs_done",   32'(if4.o_fcs_valid), 32'd0);

      // Empty frame
      send4(32'h0, 4'h0, 1'b1, 1'b0);
      chk("empty_crc",       if4.o_crc,       32'd0);
      chk("empty_fcs_valid", 32'(if4.o_fcs_valid), 32'd1);
      chk("empty_fcs_data",  if4.o_fcs_data,  32'd0);
      chk("empty_fcs_last",  32'(if4.o_fcs_last),  32'd1);
      @(negedge clk);

      // Abort mid-frame; the aborted-cycle last beat must be discarded
      send4(32'h0000_3231, 4'h3, 1'b0, 1'b0);
      if4.i_abort = 1'b1;
      send4(32'h3433_3231, 4'hF, 1'b1, 1'b0);
      if4.i_abort = 1'b0;
      chk("abort_crc_hold",  if4.o_crc,       32'd0);
      chk("abort_no_fcs",    32'(if4.o_fcs_valid), 32'd0);
      chk("abort_ready",     32'(if4.o_ready),     32'd1);
      frame4_123456789();
      chk("abort_then_crc",  if4.o_crc,       32'hCBF4_3926);
      @(negedge clk);

      // Abort during a stalled EMIT
      if4.i_fcs_ready = 1'b0;
      send4(32'h0, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("stall_valid", 32'(if4.o_fcs_valid), 32'd1);
      chk("stall_ready", 32'(if4.o_ready),     32'd0);
      if4.i_abort = 1'b1;
      @(negedge clk);
      if4.i_abort = 1'b0;
      chk("emit_abort_valid", 32'(if4.o_fcs_valid), 32'd0);
      chk("emit_abort_ready", 32'(if4.o_ready),     32'd1);
      chk("emit_abort_crc",   if4.o_crc,       32'd0);
      if4.i_fcs_ready = 1'b1;

      // 1-byte generate with FCS backpressure 1,0,0,1,1,1
      frame1_123456789();
      if1.i_fcs_ready = 1'b1;
      chk("g1_crc",   if1.o_crc,              32'hCBF4_3926);
      chk("g1_b0",    32'(if1.o_fcs_data),    32'h26);
      chk("g1_l0",    32'(if1.o_fcs_last),    32'd0);
      @(negedge clk); if1.i_fcs_ready = 1'b0;
      chk("g1_b1",    32'(if1.o_fcs_data),    32'h39);
      @(negedge clk); if1.i_fcs_ready = 1'b0;
      chk("g1_b1_hold1", 32'(if1.o_fcs_data), 32'h39);
      chk("g1_valid_hold", 32'(if1.o_fcs_valid), 32'd1);
      @(negedge clk); if1.i_fcs_ready = 1'b1;
      chk("g1_b1_hold2", 32'(if1.o_fcs_data), 32'h39);
      @(negedge clk);
      chk("g1_b2",    32'(if1.o_fcs_data),    32'hF4);
      chk("g1_l2",    32'(if1.o_fcs_last),    32'd0);
      @(negedge clk);
      chk("g1_b3",    32'(if1.o_fcs_data),    32'hCB);
      chk("g1_l3",    32'(if1.o_fcs_last),    32'd1);
      @(negedge clk);
      chk("g1_end_valid", 32'(if1.o_fcs_valid), 32'd0);
      chk("g1_end_ready", 32'(if1.o_ready),     32'd1);

      // Reset during EMIT, then a clean frame
      if1.i_fcs_ready = 1'b0;
      frame1_123456789();
      chk("r1_in_emit", 32'(if1.o_fcs_valid), 32'd1);
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      chk("r1_crc",       if1.o_crc,             32'd0);
      chk("r1_fcs_valid", 32'(if1.o_fcs_valid),  32'd0);
      chk("r1_fcs_data",  32'(if1.o_fcs_data),   32'd0);
      chk("r1_fcs_last",  32'(if1.o_fcs_last),   32'd0);
      chk("r1_ready",     32'(if1.o_ready),      32'd1);
      if1.i_fcs_ready = 1'b1;
      frame1_123456789();
      chk("r1_after_crc", if1.o_crc,             32'hCBF4_3926);
      repeat (4) @(negedge clk);
      chk("r1_after_ready", 32'(if1.o_ready),    32'd1);

      // 2-byte check mode, good frame then corrupted frame back-to-back
      frame2_check(16'h3635);
      chk("c2_valid1", 32'(if2.o_chk_valid), 32'd1);
      chk("c2_ok1",    32'(if2.o_chk_ok),    32'd1);
      chk("c2_crc1",   if2.o_crc,            32'h2144_DF1C);
      chk("c2_ready",  32'(if2.o_ready),     32'd1);
      send2(16'h3231, 2'b11, 1'b0, 1'b1);
      chk("c2_pulse_w", 32'(if2.o_chk_valid), 32'd0);
      chk("c2_ok_hold", 32'(if2.o_chk_ok),    32'd1);
      send2(16'h3433, 2'b11, 1'b0, 1'b1);
      send2(16'h3636, 2'b11, 1'b0, 1'b1);
      send2(16'h3837, 2'b11, 1'b0, 1'b1);
      send2(16'h2639, 2'b11, 1'b0, 1'b1);
      send2(16'hF439, 2'b11, 1'b0, 1'b1);
      send2(16'h00CB, 2'b01, 1'b1, 1'b1);
      chk("c2_valid2", 32'(if2.o_chk_valid), 32'd1);
      chk("c2_ok2",    32'(if2.o_chk_ok),    32'd0);
      @(negedge clk);
      chk("c2_valid2_end", 32'(if2.o_chk_valid), 32'd0);
      chk("c2_ok2_hold",   32'(if2.o_chk_ok),    32'd0);

      // Reset mid-frame, then a good check frame
      send2(16'h3231, 2'b11, 1'b0, 1'b1);
      send2(16'h3433, 2'b11, 1'b0, 1'b1);
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      chk("r2_crc",       if2.o_crc,             32'd0);
      chk("r2_chk_valid", 32'(if2.o_chk_valid),  32'd0);
      chk("r2_ready",     32'(if2.o_ready),      32'd1);
      frame2_check(16'h3635);
      chk("r2_after_ok",  32'(if2.o_chk_ok),     32'd1);
      chk("r2_after_crc", if2.o_crc,             32'h2144_DF1C);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mii_net_crc_engine.md
# mii_net_crc_engine

Parametrised Ethernet CRC-32 (802.3, reflected poly 0xEDB88320) engine processing DATA_BYTES bytes per beat with byte-enables, framed by a last flag. It replaces the single-byte CRC unit in the MAC TX and RX paths. In generate mode it appends the 4-byte FCS as an output stream with backpressure. In check mode it reports a pass/fail verdict on the received FCS residue.

## Interface
- DATA_BYTES, 4: bytes per beat; legal values 1, 2, 4.
- INIT, 32'hFFFFFFFF: accumulator value at reset, after abort and after every frame end.
- XOR_OUT, 32'hFFFFFFFF: final XOR applied to the accumulator to form the CRC.
- RESIDUE, 32'hDEBB20E3: accumulator value after data+FCS that means a good frame in check mode.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mode  in  1  0 = generate, 1 = check; sampled on the accepted last beat.
- i_abort  in  1  synchronous frame abort.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid & o_ready.
- i_data  in  8*DATA_BYTES  byte k = i_data[8k+7:8k]; byte 0 is first on the wire.
- i_keep  in  DATA_BYTES  byte enables.
- i_last  in  1  final beat of the frame.
- o_crc  out  32  CRC of the last completed frame: accumulator ^ XOR_OUT.
- o_fcs_valid  out  1  FCS output beat valid (generate mode).
- i_fcs_ready  in  1  FCS output backpressure.
- o_fcs_data  out  8*DATA_BYTES  FCS bytes, wire order: o_crc[7:0] first.
- o_fcs_last  out  1  final FCS beat.
- o_chk_valid  out  1  one-cycle verdict pulse (check mode).
- o_chk_ok  out  1  verdict; valid only with o_chk_valid.

## Operation
- States:
  - ACC: o_ready=1.
  - EMIT: o_ready=0.
- Reset:
  - state=ACC, accumulator=INIT, o_crc=0.
  - o_fcs_valid=0, o_fcs_data=0, o_fcs_last=0.
  - o_chk_valid=0, o_chk_ok=0.
- Per accepted beat, bytes with i_keep[k]=1 are folded into the accumulator in ascending k, byte-serial in a single cycle: acc = T[acc[7:0]^b] ^ (acc>>8).
- Bytes with keep=0 are skipped. Gaps in i_keep are legal and are simply skipped.
- Only the last beat may be partial. A last beat with i_keep=0 ends the frame with no data.
- Accepted last beat:
  - o_crc <= folded accumulator ^ XOR_OUT.
  - accumulator <= INIT.
  - Generate mode: go to EMIT.
  - Check mode: o_chk_valid=1 and o_chk_ok=(folded accumulator == RESIDUE) next cycle; stay in ACC.
- EMIT:
  - Emits 4/DATA_BYTES beats, each DATA_BYTES bytes of o_crc in wire order. Beat j carries o_crc bytes j*DATA_BYTES upward.
  - A beat advances when o_fcs_valid & i_fcs_ready.
  - o_fcs_last is set on the final beat. After it is accepted, return to ACC.
  - o_fcs_data and o_fcs_last hold stable while stalled.
- i_abort:
  - Next cycle: accumulator=INIT, state=ACC, o_fcs_valid=0.
  - Any beat presented in the same cycle is discarded, including a last beat: no o_crc update, no verdict.
  - o_crc is unchanged.
- i_reset has priority over i_abort. i_abort has priority over data.
- Back-to-back frames in check mode need no idle cycle: a new first beat may be accepted the cycle after last.

## Timing
- Accumulator update latency: 1 cycle after acceptance.
- o_crc valid on the cycle after the accepted last beat.
- Generate mode:
  - o_fcs_valid rises the cycle after the accepted last beat.
  - With i_fcs_ready held high, EMIT lasts 4/DATA_BYTES cycles.
  - o_ready returns high the cycle after the final FCS beat is accepted.
- Check mode: o_chk_valid is exactly 1 cycle wide, 1 cycle after the last beat. o_chk_ok holds until the next verdict.
- o_ready is a function of state only, with no combinational path from i_valid.

## Test plan
- DATA_BYTES=4, generate mode: beats 0x34333231, 0x38373635, then 0x00000039 with keep=0001 and last. Required: o_crc=0xCBF43926; one FCS beat 0xCBF43926 with o_fcs_last; o_ready low for exactly 1 cycle.
- DATA_BYTES=1, generate mode, same 9 bytes, with i_fcs_ready toggling 1,0,0,1,1,1. Required: FCS bytes 0x26, 0x39, 0xF4, 0xCB in order, held stable while stalled, o_fcs_last on 0xCB.
- DATA_BYTES=2, check mode: "123456789" followed by 26 39 F4 CB. Required: o_chk_ok=1. Then the same frame with 0x35 flipped to 0x36 back-to-back. Required: o_chk_ok=0, with both verdicts one cycle after their last beats.
- Empty frame: single last beat with keep=0 in generate mode. Required: o_crc=0x00000000 and FCS bytes 00 00 00 00.
- i_abort mid-frame after 0x31 0x32, then "123456789". Required: o_crc=0xCBF43926.
- i_abort asserted during EMIT while stalled. Required: o_fcs_valid drops next cycle and o_ready=1.
- i_reset asserted during EMIT and mid-frame. Required: all outputs at reset values next cycle, and a following frame gives the correct CRC.
